// File: rtl/dbg_mem_port.sv
// Debug-port master for the dual-port data RAM: single/burst read and fill commands in, registered RAM strobes out.
// Optional address range checking is enabled by defining DBG_MEM_RANGE_CHECK_EN.
module dbg_mem_port #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   input  logic [3:0]        cmd_be,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_last,
   output logic [ADDR_W-1:0] addrb,
   output logic [31:0]       dinb,
   output logic [3:0]        web,
   input  logic [31:0]       doutb,
   output logic              busy
);

`ifdef DBG_MEM_RANGE_CHECK_EN
   localparam logic RANGE_CHECK = 1'b1;
`else
   localparam logic RANGE_CHECK = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      RD_ADDR = 3'd2,
      RD_WAIT = 3'd3,
      RD_RESP = 3'd4,
      WR_RESP = 3'd5
   } state_t;

   function automatic logic addr_err(input logic [ADDR_W-1:0] a);
      return RANGE_CHECK & (|a[ADDR_W-1:18]);
   endfunction

   state_t             r_state, w_state_nxt;
   logic [ADDR_W-1:0]  r_cur, w_cur_nxt;
   logic [LEN_W-1:0]   r_cnt, w_cnt_nxt;
   logic [3:0]         r_be, w_be_nxt;
   logic               r_sticky, w_sticky_nxt;
   logic               r_cmd_ready, w_cmd_ready_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_rsp_valid, w_rsp_valid_nxt;
   logic [31:0]        r_rsp_rdata, w_rsp_rdata_nxt;
   logic               r_rsp_err, w_rsp_err_nxt;
   logic               r_rsp_last, w_rsp_last_nxt;
   logic [ADDR_W-1:0]  r_addrb, w_addrb_nxt;
   logic [31:0]        r_dinb, w_dinb_nxt;
   logic [3:0]         r_web, w_web_nxt;
   logic [ADDR_W-1:0]  w_acc_addr;
   logic [ADDR_W-1:0]  w_cur_inc;

   assign w_acc_addr = cmd_addr & ~ADDR_W'(3);
   assign w_cur_inc  = r_cur + ADDR_W'(4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cur       <= '0;
         r_cnt       <= '0;
         r_be        <= '0;
         r_sticky    <= 1'b0;
         r_cmd_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_last  <= 1'b0;
         r_addrb     <= '0;
         r_dinb      <= '0;
         r_web       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cur       <= w_cur_nxt;
         r_cnt       <= w_cnt_nxt;
         r_be        <= w_be_nxt;
         r_sticky    <= w_sticky_nxt;
         r_cmd_ready <= w_cmd_ready_nxt;
         r_busy      <= w_busy_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_rsp_last  <= w_rsp_last_nxt;
         r_addrb     <= w_addrb_nxt;
         r_dinb      <= w_dinb_nxt;
         r_web       <= w_web_nxt;
      end
   end

   // Every output is registered, so each branch computes what the next state presents.
   always_comb begin
      w_state_nxt     = r_state;
      w_cur_nxt       = r_cur;
      w_cnt_nxt       = r_cnt;
      w_be_nxt        = r_be;
      w_sticky_nxt    = r_sticky;
      w_rsp_valid_nxt = r_rsp_valid;
      w_rsp_rdata_nxt = r_rsp_rdata;
      w_rsp_err_nxt   = r_rsp_err;
      w_rsp_last_nxt  = r_rsp_last;
      w_addrb_nxt     = r_addrb;
      w_dinb_nxt      = r_dinb;
      w_web_nxt       = '0;

      case (r_state)
         IDLE: begin
            if (cmd_valid && r_cmd_ready) begin
               w_cur_nxt    = w_acc_addr;
               w_cnt_nxt    = cmd_len;
               w_be_nxt     = cmd_be;
               w_addrb_nxt  = w_acc_addr;
               w_sticky_nxt = 1'b0;
               if (cmd_we) begin
                  w_state_nxt  = WR;
                  w_dinb_nxt   = cmd_wdata;
                  w_sticky_nxt = addr_err(w_acc_addr);
                  w_web_nxt    = addr_err(w_acc_addr) ? 4'h0 : cmd_be;
               end else begin
                  w_state_nxt = RD_ADDR;
               end
            end
         end
         WR: begin
            if (r_cnt == '0) begin
               w_state_nxt     = WR_RESP;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_last_nxt  = 1'b1;
               w_rsp_rdata_nxt = '0;
               w_rsp_err_nxt   = r_sticky;
            end else begin
               w_cur_nxt    = w_cur_inc;
               w_cnt_nxt    = r_cnt - 1'b1;
               w_addrb_nxt  = w_cur_inc;
               w_sticky_nxt = r_sticky | addr_err(w_cur_inc);
               w_web_nxt    = addr_err(w_cur_inc) ? 4'h0 : r_be;
            end
         end
         WR_RESP: begin
            if (rsp_ready) begin
               w_state_nxt     = IDLE;
               w_rsp_valid_nxt = 1'b0;
               w_rsp_last_nxt  = 1'b0;
               w_rsp_err_nxt   = 1'b0;
            end
         end
         RD_ADDR: begin
            w_state_nxt = RD_WAIT;
         end
         RD_WAIT: begin
            // doutb now reflects the address presented during RD_ADDR.
            w_state_nxt     = RD_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_last_nxt  = (r_cnt == '0);
            w_rsp_err_nxt   = addr_err(r_cur);
            w_rsp_rdata_nxt = addr_err(r_cur) ? 32'h0 : doutb;
         end
         RD_RESP: begin
            if (rsp_ready) begin
               w_rsp_valid_nxt = 1'b0;
               w_rsp_last_nxt  = 1'b0;
               w_rsp_err_nxt   = 1'b0;
               if (r_cnt == '0) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = RD_ADDR;
                  w_cur_nxt   = w_cur_inc;
                  w_cnt_nxt   = r_cnt - 1'b1;
                  w_addrb_nxt = w_cur_inc;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      w_cmd_ready_nxt = (w_state_nxt == IDLE);
      w_busy_nxt      = (w_state_nxt != IDLE);
   end

   assign cmd_ready = r_cmd_ready;
   assign busy      = r_busy;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign rsp_last  = r_rsp_last;
   assign addrb     = r_addrb;
   assign dinb      = r_dinb;
   assign web       = r_web;

endmodule

// File: tb/tb_dbg_mem_port.sv
// Directed bench for dbg_mem_port with a byte-writable synchronous RAM model on the debug port.
// Range-check expectations follow DBG_MEM_RANGE_CHECK_EN when the bench is built with it.
module tb_dbg_mem_port;

`ifdef DBG_MEM_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_we = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_be = '0;
   logic [7:0]  cmd_len = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_last;
   logic [31:0] addrb;
   logic [31:0] dinb;
   logic [3:0]  web;
   logic [31:0] doutb;
   logic        busy;

   logic [31:0] mem [0:1023];
   logic [31:0] rd_exp [0:3];
   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   dbg_mem_port #(.ADDR_W(32), .LEN_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be), .cmd_len(cmd_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_last(rsp_last),
      .addrb(addrb), .dinb(dinb), .web(web), .doutb(doutb), .busy(busy)
   );

   always #5 clk = ~clk;

   // RAM debug port: one-cycle synchronous read, read-before-write.
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (web[b]) mem[addrb[11:2]][8*b +: 8] <= dinb[8*b +: 8];
      doutb <= mem[addrb[11:2]];
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit bad(input logic [31:0] a);
      return RC && (a[31:18] != 14'h0);
   endfunction

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                           input int unsigned len);
      logic [31:0] cur;
      logic        e;
      chk("wr_cmd_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = a; cmd_wdata = d; cmd_be = be;
      cmd_len = 8'(len); rsp_ready = 1'b0;
      step();
      cmd_valid = 1'b0;
      cur = {a[31:2], 2'b00};
      e = 1'b0;
      for (int unsigned i = 0; i <= len; i++) begin
         chk("wr_addrb", addrb, cur);
         chk("wr_web", 32'(web), bad(cur) ? 32'd0 : 32'(be));
         chk("wr_dinb", dinb, d);
         chk("wr_rsp_valid_lo", 32'(rsp_valid), 32'd0);
         e = e | bad(cur);
         cur = cur + 32'd4;
         step();
      end
      chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("wr_rsp_last", 32'(rsp_last), 32'd1);
      chk("wr_rsp_err", 32'(rsp_err), 32'(e));
      chk("wr_rsp_rdata", rsp_rdata, 32'd0);
      chk("wr_web_resp", 32'(web), 32'd0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("wr_done_valid", 32'(rsp_valid), 32'd0);
      chk("wr_done_ready", 32'(cmd_ready), 32'd1);
      chk("wr_done_busy", 32'(busy), 32'd0);
   endtask

   task automatic do_read(input logic [31:0] a, input int unsigned len);
      logic [31:0] cur;
      chk("rd_cmd_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = a; cmd_len = 8'(len); rsp_ready = 1'b1;
      step();
      cmd_valid = 1'b0;
      cur = {a[31:2], 2'b00};
      for (int unsigned i = 0; i <= len; i++) begin
         chk("rd_addrb", addrb, cur);
         chk("rd_valid_c1", 32'(rsp_valid), 32'd0);
         chk("rd_web", 32'(web), 32'd0);
         step();
         chk("rd_valid_c2", 32'(rsp_valid), 32'd0);
         step();
         chk("rd_valid_c3", 32'(rsp_valid), 32'd1);
         chk("rd_rdata", rsp_rdata, bad(cur) ? 32'd0 : rd_exp[i]);
         chk("rd_err", 32'(rsp_err), 32'(bad(cur)));
         chk("rd_last", 32'(rsp_last), (i == len) ? 32'd1 : 32'd0);
         step();
         cur = cur + 32'd4;
      end
      rsp_ready = 1'b0;
      chk("rd_done_valid", 32'(rsp_valid), 32'd0);
      chk("rd_done_ready", 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      // reset values
      repeat (3) step();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_addrb", addrb, 32'd0);
      chk("rst_web", 32'(web), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      chk("rel_cmd_ready_lo", 32'(cmd_ready), 32'd0);
      step();
      chk("rel_cmd_ready_hi", 32'(cmd_ready), 32'd1);

      // single write then read back
      do_write(32'h100, 32'hDEADBEEF, 4'hF, 0);
      rd_exp[0] = 32'hDEADBEEF;
      do_read(32'h100, 0);

      // partial byte-enable write; unaligned command address
      do_write(32'h300, 32'h12345678, 4'hF, 0);
      do_write(32'h303, 32'h0000AAAA, 4'h3, 0);
      rd_exp[0] = 32'h1234AAAA;
      do_read(32'h300, 0);

      // four-word read burst
      do_write(32'h200, 32'h11111111, 4'hF, 0);
      do_write(32'h204, 32'h22222222, 4'hF, 0);
      do_write(32'h208, 32'h33333333, 4'hF, 0);
      do_write(32'h20C, 32'h44444444, 4'hF, 0);
      rd_exp[0] = 32'h11111111; rd_exp[1] = 32'h22222222;
      rd_exp[2] = 32'h33333333; rd_exp[3] = 32'h44444444;
      do_read(32'h200, 3);

      // response stall with a competing command held on the channel
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h100; cmd_len = 8'd0; rsp_ready = 1'b0;
      step();
      cmd_valid = 1'b0;
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 32'(rsp_valid), 32'd1);
         chk("stall_rdata", rsp_rdata, 32'hDEADBEEF);
         chk("stall_addrb", addrb, 32'h100);
         chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
         chk("stall_web", 32'(web), 32'd0);
         cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h500; cmd_be = 4'hF;
         step();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      chk("stall_end_valid", 32'(rsp_valid), 32'd1);
      step();
      rsp_ready = 1'b0;
      chk("stall_done_valid", 32'(rsp_valid), 32'd0);
      chk("stall_done_ready", 32'(cmd_ready), 32'd1);
      chk("stall_no_write", 32'(web), 32'd0);

      // reset in the second cycle of a four-word fill
      do_write(32'h400, 32'h0, 4'hF, 3);
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h400; cmd_wdata = 32'hCAFEF00D;
      cmd_be = 4'hF; cmd_len = 8'd3;
      step();
      cmd_valid = 1'b0;
      chk("rfill_web_c1", 32'(web), 32'hF);
      step();
      chk("rfill_addrb_c2", addrb, 32'h404);
      rst_n = 1'b0;
      #1;
      chk("rfill_web_async", 32'(web), 32'd0);
      chk("rfill_addrb_async", addrb, 32'd0);
      chk("rfill_dinb_async", dinb, 32'd0);
      chk("rfill_busy_async", 32'(busy), 32'd0);
      chk("rfill_ready_async", 32'(cmd_ready), 32'd0);
      repeat (2) step();
      rst_n = 1'b1;
      chk("rfill_ready_lo", 32'(cmd_ready), 32'd0);
      step();
      chk("rfill_ready_hi", 32'(cmd_ready), 32'd1);
      chk("rfill_no_rsp", 32'(rsp_valid), 32'd0);
      rd_exp[0] = 32'hCAFEF00D;
      do_read(32'h400, 0);
      rd_exp[0] = 32'h0;
      do_read(32'h404, 0);

      // out-of-range address (aliases word 0 in the RAM model when unchecked)
      do_write(32'h00040000, 32'h5A5A5A5A, 4'hF, 0);
      rd_exp[0] = 32'h5A5A5A5A;
      do_read(32'h00040000, 0);

      // burst wrapping past the top of the address space
      do_write(32'hFFFFFFFC, 32'h77777777, 4'hF, 1);
      rd_exp[0] = 32'h77777777;
      do_read(32'h0, 0);

      // maximum burst length
      do_write(32'h800, 32'h0F0F0F0F, 4'hF, 255);
      rd_exp[0] = 32'h0F0F0F0F;
      do_read(32'hBFC, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      n_err++;
      $display("FAIL timeout: simulation did not complete");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "timeout");
   end

endmodule
